// File: rtl/poker_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poker_types (package)
// Brief    : Shared table-game types: chip width, seat count, player actions
//            and the betting-round state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package poker_types;

    localparam int MAX_STACK_W = 16;
    localparam int NUM_SEATS   = 8;

    typedef enum logic [2:0] {
        FOLD  = 3'd0,
        CHECK = 3'd1,
        CALL  = 3'd2,
        RAISE = 3'd3,
        ALLIN = 3'd4
    } action_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FIND     = 3'd1,
        WAIT_ACT = 3'd2,
        APPLY    = 3'd3,
        DONE     = 3'd4
    } round_state_t;

    // Number of set bits in a seat mask.
    function automatic logic [3:0] seat_count(input logic [NUM_SEATS-1:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            n = n + {3'b000, m[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seat_rr_finder.sv
`default_nettype none
// ============================================================================
// Module   : seat_rr_finder
// Brief    : Wrap-around search for the first set seat bit at or after a
//            start seat (seat 7 wraps to seat 0).
// Revision : 1.0 - initial release
// ============================================================================
module seat_rr_finder
    import poker_types::*;
(
    input  logic [NUM_SEATS-1:0] mask,
    input  logic [2:0]           start,
    output logic [2:0]           seat,
    output logic                 found
);

    logic [NUM_SEATS-1:0] rot;
    logic [2:0]           offset;

    // Rotate the mask so the start seat sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot    = '0;
        offset = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            rot[i] = mask[start + 3'(i)];
        end
        for (int i = NUM_SEATS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 3'(i);
                found  = 1'b1;
            end
        end
        seat = start + offset;
    end

endmodule
`default_nettype wire

// File: rtl/betting_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : betting_round_ctrl
// Brief    : Sequences one betting round: picks the next seat owed an action,
//            validates and applies FOLD/CHECK/CALL/RAISE/ALLIN, tracks the
//            current bet and minimum raise, and reports the round outcome.
// Revision : 1.0 - initial release
// ============================================================================
module betting_round_ctrl
    import poker_types::*;
#(
    parameter int unsigned BIG_BLIND = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             first_seat,
    input  logic [NUM_SEATS-1:0]   in_hand,
    input  logic [NUM_SEATS-1:0]   all_in,
    input  logic                   act_valid,
    input  action_t                act_type,
    input  logic [MAX_STACK_W-1:0] act_amount,
    output logic                   act_ready,
    output logic [2:0]             to_act,
    output logic                   pot_add_valid,
    output logic [MAX_STACK_W-1:0] pot_add,
    output logic [MAX_STACK_W-1:0] current_bet,
    output logic [NUM_SEATS-1:0]   folded,
    output logic                   act_err,
    output logic                   round_done,
    output logic                   hand_won,
    output logic [2:0]             winner_seat
);

    localparam logic [MAX_STACK_W-1:0] c_big_blind = MAX_STACK_W'(BIG_BLIND);

    // ------------------------------------------------------------------
    // Round state
    // ------------------------------------------------------------------
    round_state_t                          state_q,       state_d;
    logic [NUM_SEATS-1:0]                  live_q,        live_d;
    logic [NUM_SEATS-1:0]                  pending_q,     pending_d;
    logic [NUM_SEATS-1:0]                  all_in_q,      all_in_d;
    logic [NUM_SEATS-1:0]                  folded_q,      folded_d;
    logic [NUM_SEATS-1:0][MAX_STACK_W-1:0] committed_q,   committed_d;
    logic [MAX_STACK_W-1:0]                current_bet_q, current_bet_d;
    logic [MAX_STACK_W-1:0]                min_raise_q,   min_raise_d;
    logic [2:0]                            scan_ptr_q,    scan_ptr_d;
    logic [2:0]                            to_act_q,      to_act_d;
    action_t                               act_type_q,    act_type_d;
    logic [MAX_STACK_W-1:0]                act_amount_q,  act_amount_d;

    // ------------------------------------------------------------------
    // Action evaluation
    // ------------------------------------------------------------------
    logic [2:0]             next_seat;
    logic                   next_found;
    logic [2:0]             sole_seat;
    logic                   sole_found;
    logic [3:0]             live_count;
    logic [NUM_SEATS-1:0]   actor_bit;
    logic [MAX_STACK_W-1:0] owed;
    logic [MAX_STACK_W-1:0] pay;
    logic [MAX_STACK_W-1:0] new_commit;
    logic [MAX_STACK_W-1:0] raise_inc;
    logic                   legal;
    logic                   bet_up;
    logic                   full_raise;

    // Next seat still owed an action, scanning from the rotating pointer.
    seat_rr_finder u_next_actor (
        .mask  (pending_q),
        .start (scan_ptr_q),
        .seat  (next_seat),
        .found (next_found)
    );

    // Lowest live seat; it is the winner whenever exactly one seat is live.
    seat_rr_finder u_sole_live (
        .mask  (live_q),
        .start (3'd0),
        .seat  (sole_seat),
        .found (sole_found)
    );

    assign live_count = seat_count(live_q);

    // Judge the registered action against the current bet and minimum raise.
    always_comb begin
        actor_bit = NUM_SEATS'(1) << to_act_q;
        owed      = current_bet_q - committed_q[to_act_q];
        legal     = 1'b1;
        pay       = '0;
        case (act_type_q)
            FOLD: begin
                pay = '0;
            end
            CHECK: begin
                legal = (owed == '0);
            end
            CALL: begin
                // A call with nothing owed pays zero, which is a check.
                pay = owed;
            end
            RAISE: begin
                pay   = act_amount_q;
                legal = (committed_q[to_act_q] + act_amount_q) >= (current_bet_q + min_raise_q);
            end
            ALLIN: begin
                pay = act_amount_q;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        new_commit = committed_q[to_act_q] + pay;
        raise_inc  = new_commit - current_bet_q;
        bet_up     = new_commit > current_bet_q;
        full_raise = bet_up && (raise_inc >= min_raise_q);
    end

    // Round sequencing and betting-state updates.
    always_comb begin
        state_d       = state_q;
        live_d        = live_q;
        pending_d     = pending_q;
        all_in_d      = all_in_q;
        folded_d      = folded_q;
        committed_d   = committed_q;
        current_bet_d = current_bet_q;
        min_raise_d   = min_raise_q;
        scan_ptr_d    = scan_ptr_q;
        to_act_d      = to_act_q;
        act_type_d    = act_type_q;
        act_amount_d  = act_amount_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    live_d        = in_hand;
                    pending_d     = in_hand & ~all_in;
                    all_in_d      = all_in;
                    folded_d      = '0;
                    committed_d   = '0;
                    current_bet_d = '0;
                    min_raise_d   = c_big_blind;
                    scan_ptr_d    = first_seat;
                    state_d       = FIND;
                end
            end
            FIND: begin
                if (!next_found || (live_count <= 4'd1)) begin
                    state_d = DONE;
                end else begin
                    to_act_d = next_seat;
                    state_d  = WAIT_ACT;
                end
            end
            WAIT_ACT: begin
                if (act_valid) begin
                    act_type_d   = act_type;
                    act_amount_d = act_amount;
                    state_d      = APPLY;
                end
            end
            APPLY: begin
                if (!legal) begin
                    // Illegal action: nothing changes, the same seat is asked again.
                    state_d = WAIT_ACT;
                end else begin
                    committed_d[to_act_q] = new_commit;
                    if (act_type_q == FOLD) begin
                        live_d   = live_q & ~actor_bit;
                        folded_d = folded_q | actor_bit;
                    end
                    if (act_type_q == ALLIN) begin
                        all_in_d = all_in_q | actor_bit;
                    end
                    if (bet_up) begin
                        current_bet_d = new_commit;
                    end
                    if (full_raise) begin
                        // A full raise re-opens the action to every live seat that can still act.
                        min_raise_d = raise_inc;
                        pending_d   = live_q & ~all_in_d & ~actor_bit;
                    end else begin
                        pending_d   = pending_q & ~actor_bit;
                    end
                    scan_ptr_d = to_act_q + 3'd1;
                    state_d    = FIND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any round in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            live_q        <= '0;
            pending_q     <= '0;
            all_in_q      <= '0;
            folded_q      <= '0;
            committed_q   <= '0;
            current_bet_q <= '0;
            min_raise_q   <= '0;
            scan_ptr_q    <= '0;
            to_act_q      <= '0;
            act_type_q    <= FOLD;
            act_amount_q  <= '0;
        end else begin
            state_q       <= state_d;
            live_q        <= live_d;
            pending_q     <= pending_d;
            all_in_q      <= all_in_d;
            folded_q      <= folded_d;
            committed_q   <= committed_d;
            current_bet_q <= current_bet_d;
            min_raise_q   <= min_raise_d;
            scan_ptr_q    <= scan_ptr_d;
            to_act_q      <= to_act_d;
            act_type_q    <= act_type_d;
            act_amount_q  <= act_amount_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pulses are decoded from the registered state, so every one
    // of them is low in IDLE (and therefore right after reset).
    // ------------------------------------------------------------------
    assign act_ready     = (state_q == WAIT_ACT);
    assign to_act        = to_act_q;
    assign pot_add_valid = (state_q == APPLY) && legal && (pay != '0);
    assign pot_add       = pot_add_valid ? pay : '0;
    assign current_bet   = current_bet_q;
    assign folded        = folded_q;
    assign act_err       = (state_q == APPLY) && !legal;
    assign round_done    = (state_q == DONE);
    assign hand_won      = round_done && (live_count == 4'd1) && sole_found;
    assign winner_seat   = hand_won ? sole_seat : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_betting_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_betting_round_ctrl
// Brief    : Self-checking bench for betting_round_ctrl: directed scenarios
//            followed by randomized rounds against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_betting_round_ctrl;
    import poker_types::*;

    localparam int BB = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [2:0]             first_seat;
    logic [7:0]             in_hand;
    logic [7:0]             all_in;
    logic                   act_valid;
    action_t                act_type;
    logic [MAX_STACK_W-1:0] act_amount;
    logic                   act_ready;
    logic [2:0]             to_act;
    logic                   pot_add_valid;
    logic [MAX_STACK_W-1:0] pot_add;
    logic [MAX_STACK_W-1:0] current_bet;
    logic [7:0]             folded;
    logic                   act_err;
    logic                   round_done;
    logic                   hand_won;
    logic [2:0]             winner_seat;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the round
    logic [7:0] m_live, m_pend, m_allin, m_fold;
    int         m_comm [8];
    int         m_bet, m_minr;
    int         m_scan;
    int         m_seat;

    always #5 clk = ~clk;

    betting_round_ctrl #(.BIG_BLIND(BB)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .first_seat    (first_seat),
        .in_hand       (in_hand),
        .all_in        (all_in),
        .act_valid     (act_valid),
        .act_type      (act_type),
        .act_amount    (act_amount),
        .act_ready     (act_ready),
        .to_act        (to_act),
        .pot_add_valid (pot_add_valid),
        .pot_add       (pot_add),
        .current_bet   (current_bet),
        .folded        (folded),
        .act_err       (act_err),
        .round_done    (round_done),
        .hand_won      (hand_won),
        .winner_seat   (winner_seat)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int popc(input logic [7:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic int lowest_seat(input logic [7:0] m);
        int s;
        s = 0;
        for (int i = 7; i >= 0; i--) if (m[i]) s = i;
        return s;
    endfunction

    task automatic m_start(input logic [7:0] ih, input logic [7:0] ai, input int fs);
        m_live  = ih;
        m_pend  = ih & ~ai;
        m_allin = ai;
        m_fold  = '0;
        for (int i = 0; i < 8; i++) m_comm[i] = 0;
        m_bet   = 0;
        m_minr  = BB;
        m_scan  = fs;
    endtask

    // Round over, or else pick the next pending seat going round the table.
    task automatic m_find(output bit over);
        bit got;
        over = (m_pend == 8'h00) || (popc(m_live) <= 1);
        got  = 1'b0;
        if (!over) begin
            for (int i = 0; i < 8; i++) begin
                if (!got && m_pend[(m_scan + i) % 8]) begin
                    m_seat = (m_scan + i) % 8;
                    got    = 1'b1;
                end
            end
        end
    endtask

    task automatic m_apply(input action_t t, input int amt, output bit legal, output int pay);
        int owed, c, inc;
        owed  = m_bet - m_comm[m_seat];
        legal = 1'b1;
        pay   = 0;
        case (t)
            FOLD:    pay = 0;
            CHECK:   legal = (owed == 0);
            CALL:    pay = owed;
            RAISE:   begin pay = amt; legal = (m_comm[m_seat] + amt >= m_bet + m_minr); end
            ALLIN:   pay = amt;
            default: legal = 1'b0;
        endcase
        if (legal) begin
            if (t == FOLD) begin
                m_live[m_seat] = 1'b0;
                m_fold[m_seat] = 1'b1;
            end
            if (t == ALLIN) m_allin[m_seat] = 1'b1;
            c = m_comm[m_seat] + pay;
            m_comm[m_seat] = c;
            if (c > m_bet) begin
                inc   = c - m_bet;
                m_bet = c;
                if (inc >= m_minr) begin
                    m_minr = inc;
                    m_pend = m_live & ~m_allin;
                end
            end
            m_pend[m_seat] = 1'b0;
            m_scan = (m_seat + 1) % 8;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".act_ready"},     act_ready,     0);
        chk({tag, ".pot_add_valid"}, pot_add_valid, 0);
        chk({tag, ".pot_add"},       pot_add,       0);
        chk({tag, ".current_bet"},   current_bet,   0);
        chk({tag, ".folded"},        folded,        0);
        chk({tag, ".act_err"},       act_err,       0);
        chk({tag, ".round_done"},    round_done,    0);
        chk({tag, ".hand_won"},      hand_won,      0);
        chk({tag, ".winner_seat"},   winner_seat,   0);
        chk({tag, ".to_act"},        to_act,        0);
    endtask

    // Entered with the DUT in FIND; leaves it in WAIT_ACT or back in IDLE.
    task automatic after_find(output bit over);
        int won;
        chk("find.act_ready", act_ready, 0);
        chk("find.round_done", round_done, 0);
        m_find(over);
        step();
        if (over) begin
            won = (popc(m_live) == 1) ? 1 : 0;
            chk("done.round_done", round_done, 1);
            chk("done.hand_won", hand_won, won);
            if (won == 1) chk("done.winner_seat", winner_seat, lowest_seat(m_live));
            chk("done.act_ready", act_ready, 0);
            step();
            chk("idle.round_done", round_done, 0);
            chk("idle.hand_won", hand_won, 0);
        end else begin
            chk("wait.act_ready", act_ready, 1);
            chk("wait.to_act", to_act, m_seat);
        end
    endtask

    // Entered with the DUT in IDLE.
    task automatic start_round(input logic [7:0] ih, input logic [7:0] ai, input int fs, output bit over);
        start      = 1'b1;
        in_hand    = ih;
        all_in     = ai;
        first_seat = 3'(fs);
        step();
        start   = 1'b0;
        in_hand = 8'($urandom);
        all_in  = 8'($urandom);
        m_start(ih, ai, fs);
        after_find(over);
    endtask

    // Entered with the DUT in WAIT_ACT.
    task automatic do_act(input action_t t, input int amt, output bit over);
        bit legal;
        int pay;
        int stall;
        over  = 1'b0;
        stall = int'($urandom_range(0, 2));
        for (int k = 0; k < stall; k++) begin
            step();
            chk("stall.act_ready", act_ready, 1);
            chk("stall.to_act", to_act, m_seat);
        end
        chk("pre.current_bet", current_bet, m_bet);
        chk("pre.folded", folded, m_fold);
        act_valid  = 1'b1;
        act_type   = t;
        act_amount = (t == RAISE || t == ALLIN) ? 16'(amt) : 16'($urandom);
        start      = 1'($urandom_range(0, 1));
        step();
        act_valid  = 1'b0;
        start      = 1'b0;
        act_amount = 16'($urandom);
        m_apply(t, amt, legal, pay);
        chk("apply.pot_add_valid", pot_add_valid, (legal && pay != 0) ? 1 : 0);
        chk("apply.pot_add", pot_add, (legal && pay != 0) ? pay : 0);
        chk("apply.act_err", act_err, legal ? 0 : 1);
        chk("apply.act_ready", act_ready, 0);
        step();
        chk("post.pot_add_valid", pot_add_valid, 0);
        chk("post.act_err", act_err, 0);
        if (!legal) begin
            chk("retry.act_ready", act_ready, 1);
            chk("retry.to_act", to_act, m_seat);
        end else begin
            after_find(over);
        end
    endtask

    initial begin
        bit over;
        reset      = 1'b0;
        start      = 1'b0;
        first_seat = '0;
        in_hand    = '0;
        all_in     = '0;
        act_valid  = 1'b0;
        act_type   = FOLD;
        act_amount = '0;
        step();
        step();
        chk_zero("reset");
        reset = 1'b1;
        step();
        chk_zero("idle");

        // Everyone checks round the table from seat 3.
        start_round(8'hFF, 8'h00, 3, over);
        for (int i = 0; i < 8; i++) begin
            chk("allcheck.to_act", to_act, (3 + i) % 8);
            do_act(CHECK, 0, over);
        end

        // Raise, call, re-raise re-opens the action to the first raiser.
        start_round(8'h07, 8'h00, 0, over);
        do_act(RAISE, 4, over);
        do_act(CALL, 0, over);
        do_act(RAISE, 10, over);
        chk("reraise.to_act", to_act, 0);
        chk("reraise.current_bet", current_bet, 10);
        do_act(RAISE, 11, over);   // 15 < 10 + 6: rejected, minimum raise is now 6
        do_act(RAISE, 12, over);
        do_act(CALL, 0, over);
        do_act(CALL, 0, over);

        // Heads-up fold hands the pot to seat 2.
        start_round(8'h05, 8'h00, 0, over);
        do_act(FOLD, 0, over);

        // Short all-in raises the bet but does not re-open earlier callers.
        start_round(8'h0F, 8'h00, 0, over);
        do_act(RAISE, 10, over);
        do_act(CALL, 0, over);
        do_act(ALLIN, 13, over);
        chk("short.to_act", to_act, 3);
        chk("short.current_bet", current_bet, 13);
        do_act(CALL, 0, over);

        // Check facing a bet is rejected.
        start_round(8'h03, 8'h00, 0, over);
        do_act(RAISE, 4, over);
        do_act(CHECK, 0, over);
        chk("illegal.to_act", to_act, 1);
        chk("illegal.current_bet", current_bet, 4);
        do_act(CALL, 0, over);

        // Reset while an action handshake is being presented.
        start_round(8'hFF, 8'h00, 0, over);
        do_act(RAISE, 6, over);
        reset      = 1'b0;
        act_valid  = 1'b1;
        act_type   = CALL;
        act_amount = 16'd6;
        step();
        chk_zero("midreset");
        reset     = 1'b1;
        act_valid = 1'b0;
        step();
        chk("midreset.after.pot_add_valid", pot_add_valid, 0);
        chk("midreset.after.act_ready", act_ready, 0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] ih;
            logic [7:0] ai;
            int         n;
            int         sel;
            int         owed;
            int         amt;
            action_t    t;
            ih = 8'($urandom);
            if (popc(ih) < 2) ih = ih | 8'h81;
            ai = 8'($urandom) & 8'($urandom) & 8'($urandom) & ih;
            start_round(ih, ai, int'($urandom_range(0, 7)), over);
            n = 0;
            while (!over && n < 60) begin
                sel  = int'($urandom_range(0, 9));
                owed = m_bet - m_comm[m_seat];
                amt  = 0;
                if (n >= 30) begin
                    t = (sel == 0) ? FOLD : CALL;
                end else if (sel == 0) begin
                    t = FOLD;
                end else if (sel <= 2) begin
                    t = CHECK;
                end else if (sel <= 5) begin
                    t = CALL;
                end else if (sel <= 7) begin
                    t   = RAISE;
                    amt = owed + m_minr - 1 + int'($urandom_range(0, 4));
                end else begin
                    t   = ALLIN;
                    amt = int'($urandom_range(0, owed + m_minr + 3));
                end
                do_act(t, amt, over);
                n++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
